// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter: byte FIFO feeding an 8N1 serializer
//
// Purpose: fabric logic pushes bytes at any rate; the serializer drains them as
// back-to-back frames (start, 8 data bits LSB first, [even parity], stop) with no
// idle gap between consecutive frames.
//
// Optional feature: `define UART_TX_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit (11 bit-times per frame instead of 10).
//
// Ports:
//   i_Clock       single clock, rising edge
//   i_Reset       synchronous reset, active-high
//   i_Wr_DV       write strobe; byte accepted on this edge if !o_Full
//   i_Wr_Byte     byte to enqueue
//   o_Full        FIFO full; writes while high are dropped
//   o_Empty       FIFO empty
//   o_Fill_Count  bytes queued (excludes the byte being shifted)
//   o_Overflow    sticky dropped-write flag, cleared only by reset
//   o_TX_Active   high from first start-bit cycle to last stop-bit cycle
//   o_TX_Serial   serial line, idles high, registered
//   o_TX_Done     one-cycle pulse on the last cycle of each stop bit

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT    = 217,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Wr_DV,
    input  logic [7:0]               i_Wr_Byte,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [FIFO_DEPTH_LOG2:0] o_Fill_Count,
    output logic                     o_Overflow,
    output logic                     o_TX_Active,
    output logic                     o_TX_Serial,
    output logic                     o_TX_Done
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    // ---------------------------------------------------------------- FIFO
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count_q;
    logic [FIFO_DEPTH_LOG2:0]   count_d;
    logic                       full_q;
    logic                       empty_q;
    logic                       overflow_q;
    logic                       wr_ok;
    logic                       pop;
    logic [7:0]                 rd_data;

    // The registered full flag gates writes, so a write on the same edge as a pop
    // from a full FIFO is still rejected.
    assign wr_ok   = i_Wr_DV && !full_q;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_d = count_q;
        if (wr_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= i_Wr_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
            empty_q <= (count_d == '0);
            if (i_Wr_DV && full_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------- serializer
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [CNT_W-1:0] clk_cnt_d;
    logic [2:0]       bit_idx_q;
    logic [2:0]       bit_idx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             bit_last;
    logic             serial_d;
    logic             active_d;
    logic             done_d;
    logic             serial_q;
    logic             active_q;
    logic             done_q;

    assign bit_last = (clk_cnt_q == CNT_LAST);

    // State register; the outputs are also registered here so the line is glitch-free.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = bit_last ? '0 : clk_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = rd_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_last) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_last) begin
                    // Chain straight into the next start bit when more bytes wait.
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = rd_data;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: values the registered outputs take for the upcoming cycle.
    always_comb begin
        serial_d = 1'b1;
        active_d = (state_d != S_IDLE);
        done_d   = (state_d == S_STOP) && (clk_cnt_d == CNT_LAST);
        case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: serial_d = ^shift_d;
`endif
            default:  serial_d = 1'b1;
        endcase
    end

    assign o_Full       = full_q;
    assign o_Empty      = empty_q;
    assign o_Fill_Count = count_q;
    assign o_Overflow   = overflow_q;
    assign o_TX_Active  = active_q;
    assign o_TX_Serial  = serial_q;
    assign o_TX_Done    = done_q;

endmodule
